sha256d_nonce_sequencer: RTL and testbench
==========================================

// Module: sha256d_nonce_sequencer
// PURPOSE
//  Job controller for NUM_LANES parallel double-SHA256 lanes. Takes a job (midstate, 96-bit header tail,
//  target, nonce range), builds each lane's padded second-chunk block, and issues one nonce per cycle to
//  free lanes. Compares returned final hashes against target and queues hits in a result FIFO.
//  Sits between host job registers and the replicated two-stage SHA256 pipelines.
// PARAMETERS
//  NUM_LANES   4   number of attached SHA256d lanes (1..16)
//  NONCE_W     32  nonce counter width (<=32); nonce zero-extended into the 32-bit header word
//  RES_DEPTH   4   result FIFO depth (power of 2, >=2)
// PORTS
//  CLK             in   1              clock
//  RST             in   1              asynchronous reset, active-high
//  job_valid       in   1              job offered
//  job_ready       out  1              high only in IDLE
//  job_midstate    in   256            chunk-1 midstate, forwarded to lanes
//  job_tail        in   96             header bytes 64..75
//  job_target      in   256            hit when hash <= target (unsigned)
//  job_nonce_start in   NONCE_W        first nonce, inclusive
//  job_nonce_end   in   NONCE_W        last nonce, inclusive
//  abort           in   1              cancel current job
//  lane_start      out  NUM_LANES      one-hot, 1-cycle issue pulse
//  lane_block      out  512            {tail,nonce32,1'b1,319'b0,64'd640}, valid with lane_start
//  lane_midstate   out  256            latched job_midstate
//  lane_busy       in   NUM_LANES      lane occupied
//  lane_done       in   NUM_LANES      1-cycle completion pulse per lane
//  lane_hash       in   256*NUM_LANES  lane i final hash at [256*i +: 256], valid with lane_done[i]
//  res_valid       out  1              FIFO not empty
//  res_ready       in   1              consumer pop
//  res_nonce       out  NONCE_W        nonce of head hit
//  res_hash        out  256            hash of head hit
//  busy            out  1              state != IDLE
//  exhausted       out  1              1-cycle pulse: range fully hashed, all lanes returned
// BEHAVIOUR
//  - Reset: state IDLE, job_ready=1, lane_start=0, res_valid=0, busy=0, exhausted=0; FIFO, pending, and
//    lane-tag registers cleared. lane_block/lane_midstate reset to 0.
//  - FSM: IDLE -(job_valid&job_ready)-> RUN; RUN -(last nonce issued)-> DRAIN;
//    DRAIN -(no outstanding, no pending)-> IDLE with exhausted pulse; any non-IDLE -(abort)-> FLUSH;
//    FLUSH -(no outstanding)-> IDLE, no exhausted pulse. abort in IDLE is ignored.
//  - Job latched on accept cycle T; first lane_start no earlier than T+1.
//  - Issue in RUN: at most one lane per cycle. Lowest-index lane free: !lane_busy, not outstanding,
//    no pending hit. Nonce captured into lane tag; counter +1.
//  - Outstanding[i] set on issue, cleared on lane_done[i]. lane_done on non-outstanding lane is ignored.
//  - Range end: inclusive compare against job_nonce_end via last flag, so end=all-ones does not wrap.
//    start>end: nothing issued, RUN->DRAIN at T+1, exhausted at T+2.
//  - Compare: at lane_done[i], hit if lane_hash[i] <= target; hit registered into pending[i] with tag.
//    Simultaneous hits all captured. Misses discarded. In FLUSH, done results are discarded.
//  - Result push: one pending hit per cycle, round-robin over lanes, into FIFO when not full.
//    Earliest res_valid is D+2 for lane_done at cycle D.
//  - FIFO full: hits stay pending and the lane is not reissued; this is the backpressure. No hit dropped.
//  - Pop: res_valid&res_ready. Push and pop in the same cycle are allowed when full.
//  - FIFO contents survive abort and new jobs.
//  - Reset mid-job: everything returns to reset values immediately, including the FIFO.
// TESTING
//  1. NUM_LANES=4, start=0,end=7, target=0, lanes return nonzero hashes ->
//     8 issues, nonces 0..7 lowest-free-lane order; no res_valid; one exhausted pulse.
//  2. target=all-ones, start=10,end=12 -> 3 results, nonces {10,11,12} (arrival order);
//     hash == lane_hash; exhausted after last pop-independent drain.
//  3. All 4 lanes done same cycle, all hits, res_ready=0, RES_DEPTH=2 ->
//     FIFO holds 2, 2 pending, those lanes not reissued; after 4 pops all 4 nonces seen exactly once.
//  4. start=32'hFFFF_FFFE,end=32'hFFFF_FFFF -> exactly 2 issues, no wrap to 0; exhausted pulse.
//  5. abort after 3 issues with 2 in flight -> no further lane_start; in-flight hits discarded;
//     busy drops once outstanding=0; no exhausted pulse; job_ready=1.
//  6. RST asserted mid-RUN with FIFO non-empty -> same cycle res_valid=0, busy=0, lane_start=0;
//     new job accepted after release.

Source files
------------

// File: rtl/sha256d_nonce_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sha256d_nonce_sequencer
// Purpose  : issues nonces to parallel SHA256d lanes, queues hashes <= target
// Revision : 1.0 - initial release
// ============================================================================
module sha256d_nonce_sequencer #(
  parameter int NUM_LANES = 4,
  parameter int NONCE_W   = 32,
  parameter int RES_DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [255:0]             job_midstate,
  input  logic [95:0]              job_tail,
  input  logic [255:0]             job_target,
  input  logic [NONCE_W-1:0]       job_nonce_start,
  input  logic [NONCE_W-1:0]       job_nonce_end,
  input  logic                     abort,
  output logic [NUM_LANES-1:0]     lane_start,
  output logic [511:0]             lane_block,
  output logic [255:0]             lane_midstate,
  input  logic [NUM_LANES-1:0]     lane_busy,
  input  logic [NUM_LANES-1:0]     lane_done,
  input  logic [256*NUM_LANES-1:0] lane_hash,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [NONCE_W-1:0]       res_nonce,
  output logic [255:0]             res_hash,
  output logic                     busy,
  output logic                     exhausted
);

  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int AW = $clog2(RES_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [95:0]          r_tail;
  logic [255:0]         r_target;
  logic [NONCE_W-1:0]   r_nonce, r_end;
  logic                 r_range_empty;
  logic [NUM_LANES-1:0] r_outst, r_pending;
  logic [NONCE_W-1:0]   r_tag      [NUM_LANES];
  logic [255:0]         r_pnd_hash [NUM_LANES];
  logic [NONCE_W-1:0]   r_fifo_nonce [RES_DEPTH];
  logic [255:0]         r_fifo_hash  [RES_DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [AW:0]          r_count;
  logic [LW-1:0]        r_rr;
  logic [NUM_LANES-1:0] r_lane_start;
  logic [511:0]         r_lane_block;
  logic [255:0]         r_lane_midstate;

  logic                 w_accept, w_issue, w_last, w_free_any, w_push_hit, w_push, w_pop, w_full;
  logic [NUM_LANES-1:0] w_free;
  logic [LW-1:0]        w_free_idx, w_push_idx;
  int                   w_j;

  assign w_free   = ~lane_busy & ~r_outst & ~r_pending;
  assign w_accept = job_valid && (r_state == S_IDLE);
  assign w_last   = (r_nonce == r_end);
  assign w_issue  = (r_state == S_RUN) && !abort && !r_range_empty && w_free_any;
  assign w_full   = (r_count == (AW+1)'(RES_DEPTH));
  assign w_pop    = (r_count != '0) && res_ready;
  // A full FIFO still accepts a push when the head is leaving this cycle.
  assign w_push   = w_push_hit && (!w_full || w_pop);

  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_LANES-1; i >= 0; i--) begin
      if (w_free[i]) begin
        w_free_any = 1'b1;
        w_free_idx = LW'(i);
      end
    end
  end

  always_comb begin
    w_push_hit = 1'b0;
    w_push_idx = '0;
    w_j        = 0;
    for (int k = NUM_LANES-1; k >= 0; k--) begin
      w_j = (int'(r_rr) + k) % NUM_LANES;
      if (r_pending[LW'(w_j)]) begin
        w_push_hit = 1'b1;
        w_push_idx = LW'(w_j);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (job_valid) w_state_nxt = S_RUN;
      S_RUN: begin
        if (abort)                                    w_state_nxt = S_FLUSH;
        else if (r_range_empty || (w_issue && w_last)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)                                     w_state_nxt = S_FLUSH;
        else if (r_outst == '0 && r_pending == '0)     w_state_nxt = S_IDLE;
      end
      S_FLUSH: if (r_outst == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state         <= S_IDLE;
      r_tail          <= '0;
      r_target        <= '0;
      r_nonce         <= '0;
      r_end           <= '0;
      r_range_empty   <= 1'b0;
      r_lane_start    <= '0;
      r_lane_block    <= '0;
      r_lane_midstate <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_lane_start <= '0;
      if (w_accept) begin
        r_tail          <= job_tail;
        r_target        <= job_target;
        r_nonce         <= job_nonce_start;
        r_end           <= job_nonce_end;
        r_range_empty   <= (job_nonce_start > job_nonce_end);
        r_lane_midstate <= job_midstate;
      end
      if (w_issue) begin
        r_lane_start <= NUM_LANES'(1) << w_free_idx;
        r_lane_block <= {r_tail, 32'(r_nonce), 1'b1, 319'b0, 64'd640};
        // Holding at the end value keeps an all-ones end from wrapping.
        if (!w_last) r_nonce <= r_nonce + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_outst   <= '0;
      r_pending <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        r_tag[i]      <= '0;
        r_pnd_hash[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (lane_done[i]) r_outst[i] <= 1'b0;
        if (w_issue && (w_free_idx == LW'(i))) begin
          r_outst[i] <= 1'b1;
          r_tag[i]   <= r_nonce;
        end
        if (w_push && (w_push_idx == LW'(i))) r_pending[i] <= 1'b0;
        if (lane_done[i] && r_outst[i] && (r_state != S_FLUSH) &&
            (lane_hash[256*i +: 256] <= r_target)) begin
          r_pending[i]  <= 1'b1;
          r_pnd_hash[i] <= lane_hash[256*i +: 256];
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rr    <= '0;
      for (int d = 0; d < RES_DEPTH; d++) begin
        r_fifo_nonce[d] <= '0;
        r_fifo_hash[d]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo_nonce[r_wptr] <= r_tag[w_push_idx];
        r_fifo_hash[r_wptr]  <= r_pnd_hash[w_push_idx];
        r_wptr               <= r_wptr + 1'b1;
        r_rr                 <= (w_push_idx == LW'(NUM_LANES-1)) ? '0 : w_push_idx + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign job_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign exhausted     = (r_state == S_DRAIN) && !abort && (r_outst == '0) && (r_pending == '0);
  assign lane_start    = r_lane_start;
  assign lane_block    = r_lane_block;
  assign lane_midstate = r_lane_midstate;
  assign res_valid     = (r_count != '0);
  assign res_nonce     = r_fifo_nonce[r_rptr];
  assign res_hash      = r_fifo_hash[r_rptr];

endmodule
`default_nettype wire

// File: tb/tb_sha256d_nonce_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256d_nonce_sequencer
// Purpose  : randomized lane models + transaction-level reference for the sequencer
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256d_nonce_sequencer;

  localparam int NL = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic            job_valid, job_ready, abort, res_valid, res_ready, busy, exhausted;
  logic [255:0]    job_midstate, job_target, lane_midstate, res_hash;
  logic [95:0]     job_tail;
  logic [31:0]     job_nonce_start, job_nonce_end, res_nonce;
  logic [NL-1:0]   lane_start, lane_busy, lane_done;
  logic [511:0]    lane_block;
  logic [256*NL-1:0] lane_hash;

  sha256d_nonce_sequencer #(.NUM_LANES(NL), .NONCE_W(32), .RES_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .job_valid(job_valid), .job_ready(job_ready),
    .job_midstate(job_midstate), .job_tail(job_tail), .job_target(job_target),
    .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end), .abort(abort),
    .lane_start(lane_start), .lane_block(lane_block), .lane_midstate(lane_midstate),
    .lane_busy(lane_busy), .lane_done(lane_done), .lane_hash(lane_hash),
    .res_valid(res_valid), .res_ready(res_ready), .res_nonce(res_nonce), .res_hash(res_hash),
    .busy(busy), .exhausted(exhausted)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Stimulus-owned mode knobs, read by the monitor
  bit chk_order = 1'b0;
  bit sync_lat  = 1'b0;
  int lat_lo = 2, lat_hi = 7;

  // Reference model state, written only by the monitor
  bit            m_aborted;
  logic [32:0]   m_start, m_end;
  logic [255:0]  m_target, m_mid;
  logic [95:0]   m_tail;
  int            m_issued, m_exh;
  bit            lm_fly [NL];
  int            lm_cnt [NL];
  logic [31:0]   lm_nonce [NL];
  logic [255:0]  lm_hash [NL];
  logic [NL-1:0] prev_free;
  logic [287:0]  exp_q[$];
  int            log_lane[$];
  logic [31:0]   log_nonce[$];
  logic [31:0]   pop_log[$];

  function automatic logic [32:0] range_size();
    return (m_end >= m_start) ? (m_end - m_start + 33'd1) : 33'd0;
  endfunction

  always @(negedge CLK) begin
    if (RST) begin
      lane_busy = '0;
      lane_done = '0;
      for (int i = 0; i < NL; i++) lm_fly[i] = 1'b0;
      exp_q.delete();
      prev_free = '1;
      m_aborted = 1'b0;
    end else begin
      check("ready_vs_busy", job_ready, !busy);
      // lane completions: hit iff hash <= target while the job is not being flushed
      lane_done = '0;
      for (int i = 0; i < NL; i++) begin
        if (lm_fly[i]) begin
          lm_cnt[i]--;
          if (lm_cnt[i] == 0) begin
            lm_fly[i] = 1'b0;
            lane_busy[i] = 1'b0;
            lane_done[i] = 1'b1;
            lane_hash[256*i +: 256] = lm_hash[i];
            if (lm_hash[i] <= m_target && !m_aborted) exp_q.push_back({lm_nonce[i], lm_hash[i]});
          end
        end
      end
      if (lane_start != '0) begin
        int ln;
        int lo;
        logic [32:0] en;
        logic [511:0] eb;
        ln = 0;
        lo = -1;
        for (int i = NL-1; i >= 0; i--) begin
          if (lane_start[i]) ln = i;
          if (prev_free[i]) lo = i;
        end
        en = m_start + 33'(m_issued);
        eb = {m_tail, en[31:0], 1'b1, 319'b0, 64'd640};
        check("start_onehot", $onehot(lane_start), 1'b1);
        check("start_after_abort", m_aborted, 1'b0);
        check("start_lane_free", prev_free[ln], 1'b1);
        if (chk_order) check("lowest_free_lane", ln, lo);
        check("nonce_in_range", en <= m_end, 1'b1);
        check("lane_block", lane_block, eb);
        check("lane_midstate", lane_midstate, m_mid);
        m_issued++;
        log_lane.push_back(ln);
        log_nonce.push_back(lane_block[415:384]);
        lm_fly[ln]   = 1'b1;
        lm_nonce[ln] = lane_block[415:384];
        lm_hash[ln]  = {$urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom} | 256'd1;
        lm_cnt[ln]   = sync_lat ? (10 - ln) : int'($urandom_range(lat_lo, lat_hi));
        lane_busy[ln] = 1'b1;
      end
      if (res_valid && res_ready) begin
        bit found;
        found = 1'b0;
        for (int q = 0; q < exp_q.size(); q++) begin
          if (!found && exp_q[q] == {res_nonce, res_hash}) begin
            found = 1'b1;
            exp_q.delete(q);
          end
        end
        check("pop_expected_hit", found, 1'b1);
        pop_log.push_back(res_nonce);
      end
      if (exhausted) begin
        bit any_fly;
        any_fly = 1'b0;
        for (int i = 0; i < NL; i++) any_fly |= lm_fly[i];
        check("exh_no_inflight", any_fly, 1'b0);
        check("exh_not_aborted", m_aborted, 1'b0);
        check("exh_all_issued", 33'(m_issued), range_size());
        m_exh++;
      end
      if (abort && busy) m_aborted = 1'b1;
      if (job_valid && job_ready) begin
        m_start   = {1'b0, job_nonce_start};
        m_end     = {1'b0, job_nonce_end};
        m_target  = job_target;
        m_mid     = job_midstate;
        m_tail    = job_tail;
        m_issued  = 0;
        m_exh     = 0;
        m_aborted = 1'b0;
      end
      for (int i = 0; i < NL; i++) prev_free[i] = !lm_fly[i] && !lane_done[i];
    end
  end

  task automatic run_job(input logic [31:0] s, input logic [31:0] e, input logic [255:0] tgt);
    @(posedge CLK); #1;
    job_nonce_start = s;
    job_nonce_end   = e;
    job_target      = tgt;
    job_midstate    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    job_tail        = {$urandom, $urandom, $urandom};
    job_valid       = 1'b1;
    @(posedge CLK); #1;
    job_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input bit rnd_ready);
    int c;
    c = 0;
    while ((busy || res_valid) && c < max_cyc) begin
      @(posedge CLK); #1;
      if (rnd_ready) res_ready = 1'($urandom_range(0, 1));
      c++;
    end
    check("job_completes_in_time", c < max_cyc, 1'b1);
  endtask

  function automatic int count_pops(input int base, input logic [31:0] n);
    int k;
    k = 0;
    for (int i = base; i < pop_log.size(); i++) if (pop_log[i] == n) k++;
    return k;
  endfunction

  localparam logic [255:0] ONES = '1;

  initial begin
    int pb, lb, c;
    logic [31:0] s, e;
    RST = 1'b1; job_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
    job_midstate = '0; job_tail = '0; job_target = '0; job_nonce_start = '0; job_nonce_end = '0;
    lane_busy = '0; lane_done = '0; lane_hash = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_job_ready", job_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_lane_start", lane_start, '0);
    check("rst_exhausted", exhausted, 1'b0);
    check("rst_lane_block", lane_block, '0);
    check("rst_lane_midstate", lane_midstate, '0);
    RST = 1'b0;

    // 1: no hits, issue order strictly lowest free lane
    chk_order = 1'b1; res_ready = 1'b1;
    lb = log_lane.size(); pb = pop_log.size();
    run_job(32'd0, 32'd7, '0);
    wait_done(300, 1'b0);
    check("t1_issued", m_issued, 8);
    check("t1_exhausted", m_exh, 1);
    check("t1_no_results", pop_log.size() - pb, 0);
    for (int i = 0; i < 4; i++) begin
      check("t1_first_lanes", log_lane[lb+i], i);
      check("t1_first_nonces", log_nonce[lb+i], 32'(i));
    end
    chk_order = 1'b0;

    // 2: every hash is a hit
    pb = pop_log.size();
    run_job(32'd10, 32'd12, ONES);
    wait_done(300, 1'b0);
    check("t2_pops", pop_log.size() - pb, 3);
    for (int n = 10; n <= 12; n++) check("t2_nonce_once", count_pops(pb, 32'(n)), 1);
    check("t2_exhausted", m_exh, 1);

    // 3: simultaneous hits on all lanes against a 2-deep FIFO
    sync_lat = 1'b1; res_ready = 1'b0;
    pb = pop_log.size(); lb = log_lane.size();
    run_job(32'd100, 32'd103, ONES);
    repeat (30) @(posedge CLK);
    #1;
    check("t3_res_valid", res_valid, 1'b1);
    check("t3_still_busy", busy, 1'b1);
    check("t3_no_reissue", log_lane.size() - lb, 4);
    check("t3_hits_held", exp_q.size(), 4);
    check("t3_no_exh_yet", m_exh, 0);
    res_ready = 1'b1;
    wait_done(100, 1'b0);
    check("t3_pops", pop_log.size() - pb, 4);
    for (int n = 100; n <= 103; n++) check("t3_nonce_once", count_pops(pb, 32'(n)), 1);
    check("t3_exhausted", m_exh, 1);
    sync_lat = 1'b0;

    // 4: range ending at all-ones must not wrap
    lb = log_nonce.size();
    run_job(32'hFFFF_FFFE, 32'hFFFF_FFFF, '0);
    wait_done(100, 1'b0);
    check("t4_issued", m_issued, 2);
    check("t4_nonce0", log_nonce[lb], 32'hFFFF_FFFE);
    check("t4_nonce1", log_nonce[lb+1], 32'hFFFF_FFFF);
    check("t4_exhausted", m_exh, 1);

    // empty range: nothing issued, single exhausted pulse
    run_job(32'd5, 32'd3, ONES);
    wait_done(50, 1'b0);
    check("empty_issued", m_issued, 0);
    check("empty_exhausted", m_exh, 1);

    // 5: abort with lanes in flight
    lat_lo = 8; lat_hi = 12;
    run_job(32'd200, 32'd299, ONES);
    c = 0;
    while (m_issued < 2 && c < 50) begin @(posedge CLK); #1; c++; end
    check("t5_reach_two_issues", c < 50, 1'b1);
    abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0;
    wait_done(200, 1'b0);
    check("t5_issued", m_issued, 3);
    check("t5_no_exhausted", m_exh, 0);
    check("t5_job_ready", job_ready, 1'b1);
    check("t5_no_leftover_hits", exp_q.size(), 0);
    lat_lo = 2; lat_hi = 7;

    // randomized jobs, random target and consumer backpressure
    for (int j = 0; j < 6; j++) begin
      s = $urandom_range(0, 1000);
      e = s + $urandom_range(0, 15);
      run_job(s, e, {8'($urandom_range(0, 127)), {31{8'hFF}}});
      wait_done(800, 1'b1);
      res_ready = 1'b1;
      check("rnd_issued", 33'(m_issued), {1'b0, e} - {1'b0, s} + 33'd1);
      check("rnd_exhausted", m_exh, 1);
      check("rnd_all_hits_popped", exp_q.size(), 0);
    end

    // 6: reset in the middle of a job with results queued
    res_ready = 1'b0;
    run_job(32'd300, 32'd400, ONES);
    c = 0;
    while (!res_valid && c < 100) begin @(posedge CLK); #1; c++; end
    check("t6_res_before_rst", res_valid, 1'b1);
    RST = 1'b1;
    #1;
    check("t6_rst_res_valid", res_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_lane_start", lane_start, '0);
    @(posedge CLK); #1;
    RST = 1'b0;
    res_ready = 1'b1;
    pb = pop_log.size();
    run_job(32'd5, 32'd6, ONES);
    wait_done(100, 1'b0);
    check("t6_post_rst_pops", pop_log.size() - pb, 2);
    check("t6_post_rst_exh", m_exh, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
